serial_comp_ctrl: RTL and testbench

- Sequencer for the single-bit comparator cell. It compares two WIDTH-bit unsigned operands serially, MSB first, through one shared 1-bit compare cell.
- It stops at the first differing bit and reports less/equal/greater with a start/busy/done handshake.
- It sits between a requesting datapath, or the board switches/FSM, and the comparator cell. It replaces a WIDTH-wide parallel comparator.

---
 rtl/comp_pkg.sv | 19 +
 rtl/cmp_cell_1b.sv | 14 +
 rtl/serial_comp_ctrl.sv | 110 +++++++++++
 tb/tb_serial_comp_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the serial comparator controller and its 1-bit cell.
package comp_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions of the less/equal/greater flags inside the result vector.
  localparam int RES_G = 0;
  localparam int RES_E = 1;
  localparam int RES_L = 2;

  typedef logic [2:0] res_t;

endpackage

// File: rtl/cmp_cell_1b.sv
// Single-bit magnitude compare cell; purely combinational.
module cmp_cell_1b (
  input  logic x,
  input  logic y,
  output logic lt,
  output logic eq,
  output logic gt
);

  assign lt = ~x &  y;
  assign gt =  x & ~y;
  assign eq = ~(x ^ y);

endmodule

// File: rtl/serial_comp_ctrl.sv
// Serial MSB-first unsigned comparator: steps one shared 1-bit cell across the
// captured operands and stops at the first differing bit.
module serial_comp_ctrl
  import comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g,
  output logic [IDX_W-1:0] bit_idx
);

  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  res_t             res;
  logic             accept;
  logic             scanning;
  logic             bit_a;
  logic             bit_b;
  logic             cell_lt;
  logic             cell_eq;
  logic             cell_gt;
  logic             last_bit;

  assign bit_a    = ra[bit_idx];
  assign bit_b    = rb[bit_idx];
  assign last_bit = (bit_idx == '0);

  cmp_cell_1b u_cell (
    .x  (bit_a),
    .y  (bit_b),
    .lt (cell_lt),
    .eq (cell_eq),
    .gt (cell_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // The unused encoding 2'd3 falls into the default arm and returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_SCAN;
      ST_SCAN: if (!cell_eq || last_bit) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    scanning = 1'b0;
    case (state)
      ST_IDLE: accept = start;
      ST_SCAN: begin
        busy     = 1'b1;
        scanning = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra      <= '0;
      rb      <= '0;
      bit_idx <= IDX_MSB;
      res     <= '0;
    end else if (accept) begin
      ra      <= a;
      rb      <= b;
      bit_idx <= IDX_MSB;
      res     <= '0;
    end else if (scanning) begin
      if (!cell_eq) begin
        res[RES_L] <= cell_lt;
        res[RES_E] <= 1'b0;
        res[RES_G] <= cell_gt;
      end else if (last_bit) begin
        res[RES_E] <= 1'b1;
      end else begin
        bit_idx <= bit_idx - IDX_W'(1);
      end
    end
  end

  assign l = res[RES_L];
  assign e = res[RES_E];
  assign g = res[RES_G];

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed bench for serial_comp_ctrl with a result/latency scoreboard.
module tb_serial_comp_ctrl;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic          busy, done, l, e, g;
  logic [IW-1:0] bit_idx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0] leg;
    int         cyc;
  } exp_t;

  exp_t q[$];

  serial_comp_ctrl #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .l       (l),
    .e       (e),
    .g       (g),
    .bit_idx (bit_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Number of SCAN cycles before the first differing bit (or WIDTH if equal).
  function automatic int exp_k(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--)
      if (x[i] != y[i]) return W - i;
    return W;
  endfunction

  function automatic exp_t make_exp(input logic [W-1:0] x, input logic [W-1:0] y, input int acc_edge);
    exp_t r;
    r.leg = {x < y, x == y, x > y};
    r.cyc = acc_edge + exp_k(x, y);
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("result_leg", {29'd0, l, e, g}, {29'd0, x.leg});
        chk("done_cycle", cyc, x.cyc);
      end
    end
  end

  // Drives a one-cycle start at a negedge; returns in the first SCAN cycle.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    q.push_back(make_exp(av, bv, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_leg", {29'd0, l, e, g}, 32'd0);
    chk("rst_bit_idx", 32'(bit_idx), 32'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Equal operands: full 8-cycle scan
    launch(8'hA5, 8'hA5);
    chk("scan_leg_clear", {29'd0, l, e, g}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("scan_busy", 32'(busy), 32'd1);
      chk("scan_bit_idx", 32'(bit_idx), 32'(7 - i));
      a = ~a;
      @(negedge clk);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy_low", 32'(busy), 32'd0);
    drain();

    // MSB differs: single SCAN cycle
    launch(8'h80, 8'h7F);
    drain();
    repeat (3) @(negedge clk);
    chk("hold_g", {29'd0, l, e, g}, 32'b001);

    // LSB differs
    launch(8'h12, 8'h13);
    drain();

    // Second start while busy is ignored
    launch(8'h40, 8'h41);
    @(negedge clk);
    a     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("hold_l", {29'd0, l, e, g}, 32'b100);

    // Asynchronous reset in the 4th SCAN cycle
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_bit_idx", 32'(bit_idx), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_bit_idx", 32'(bit_idx), 32'd7);
    chk("async_rst_leg", {29'd0, l, e, g}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", 32'(done), 32'd0);
    launch(8'h01, 8'h00);
    drain();

    // Start held high: back-to-back operations every k+2 cycles
    @(negedge clk);
    a     = 8'hC0;
    b     = 8'h40;
    start = 1'b1;
    for (int j = 0; j < 4; j++) q.push_back(make_exp(8'hC0, 8'h40, cyc + 1 + 3 * j));
    repeat (10) @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("hold_g_burst", {29'd0, l, e, g}, 32'b001);

    // A few random operands
    for (int n = 0; n < 6; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (n % 2 == 0) ? (ra ^ W'(1 << $urandom_range(0, W - 1))) : W'($urandom);
      launch(ra, rb);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
